// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: transmit arbiter FSM encoding, arbiter defaults,
// the UART register-map offsets, and a small round-robin stepping helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transmit arbiter FSM: IDLE has no owner, LOCK holds a grant.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Idle LOCK cycles tolerated before a held grant is revoked.
    localparam int UART_TX_TIMEOUT_DEFAULT = 1024;

    // Width of the arbiter idle counter.
    localparam int UART_IDLE_CNT_W = 16;

    // UART register map (byte offsets).
    localparam logic [7:0] UART_REG_DATA        = 8'h00;
    localparam logic [7:0] UART_REG_STATUS      = 8'h04;
    localparam logic [7:0] UART_REG_CTRL        = 8'h08;
    localparam logic [7:0] UART_REG_BAUD        = 8'h0C;
    localparam logic [7:0] UART_REG_ARB_TIMEOUT = 8'h10;

    // Next requester index after idx, wrapping at n.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting at last+1 and
// wrapping modulo NREQ; reports the first set request.
// Ports:
//   req  [NREQ-1:0] in  : request vector
//   last [2:0]      in  : index granted most recently
//   any             out : at least one request is set
//   idx  [2:0]      out : chosen index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic            any,
    output logic [2:0]      idx
);

    always_comb begin
        logic [2:0] cand;
        any  = 1'b0;
        idx  = 3'd0;
        cand = last;
        // Step NREQ times; the last step comes back to 'last' itself, so the
        // previous owner is considered only after everyone else.
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_next(cand, NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!any && (cand == 3'(j)) && req[j]) begin
                    any = 1'b1;
                    idx = cand;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Merges NREQ byte streams into the single UART transmitter input stream.
// A requester wins round-robin arbitration, keeps the grant until it sends a
// byte with s_tlast, and loses it early if it stays idle for TIMEOUT cycles.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   s_tdata  [NREQ*8-1:0] in   : requester bytes, requester i at [8i+7:8i]
//   s_tvalid [NREQ-1:0]   in   : per-requester byte valid
//   s_tlast  [NREQ-1:0]   in   : per-requester last byte of message
//   s_tready [NREQ-1:0]   out  : per-requester byte accepted
//   m_tdata  [7:0]        out  : byte to transmitter
//   m_tvalid              out  : m_tdata valid
//   m_tready              in   : transmitter accepts byte
//   grant    [2:0]        out  : current owner (meaningful while busy)
//   busy                  out  : a grant is held
//   timeout               out  : one-cycle pulse when a grant is revoked idle
//   dbg_state             out  : FSM state for observation
//
// Handshake: on every port a beat transfers on a rising clk edge where valid
// and ready are both 1. Valid never waits on ready; once m_tvalid is high,
// m_tdata and m_tvalid hold until the beat transfers.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = UART_TX_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ*8-1:0] s_tdata,
    input  logic [NREQ-1:0]   s_tvalid,
    input  logic [NREQ-1:0]   s_tlast,
    output logic [NREQ-1:0]   s_tready,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              timeout,
    output arb_state_e        dbg_state
);

    localparam logic [UART_IDLE_CNT_W-1:0] IDLE_LIMIT = UART_IDLE_CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]                 LAST_RST   = 3'(NREQ - 1);

    arb_state_e                 state;
    logic [2:0]                 last_grant;
    logic [UART_IDLE_CNT_W-1:0] idle_cnt;

    logic       pick_any;
    logic [2:0] pick_idx;

    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_data;
    logic       out_free;
    logic       owner_fire;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (s_tvalid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Mux the owner's stream out of the flat request buses.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == 3'(i)) begin
                owner_valid = s_tvalid[i];
                owner_last  = s_tlast[i];
                owner_data  = s_tdata[8*i +: 8];
            end
        end
    end

    // The output register can take a byte when empty or draining this cycle.
    assign out_free   = !m_tvalid || m_tready;
    assign owner_fire = (state == ST_LOCK) && owner_valid && out_free;

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_tready[i] = (state == ST_LOCK) && (grant == 3'(i)) && out_free;
        end
    end

    assign busy      = (state == ST_LOCK);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 3'd0;
            last_grant <= LAST_RST;
            idle_cnt   <= '0;
            timeout    <= 1'b0;
            m_tdata    <= 8'h00;
            m_tvalid   <= 1'b0;
        end else begin
            timeout <= 1'b0;

            // Output register: load beats the drain so throughput stays at
            // one byte per cycle while m_tready is high.
            if (owner_fire) begin
                m_tdata  <= owner_data;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    // A new grant may be issued while the previous owner's
                    // final byte is still waiting in the output register.
                    if (pick_any) begin
                        grant    <= pick_idx;
                        idle_cnt <= '0;
                        state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (owner_fire) begin
                        idle_cnt <= '0;
                        if (owner_last) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end else if (!owner_valid) begin
                        // Only a silent owner counts as idle; an owner stalled
                        // by m_tready is not.
                        if (idle_cnt == IDLE_LIMIT) begin
                            timeout    <= 1'b1;
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter (NREQ=4, TIMEOUT=8). Requesters are fed from
// per-port message buffers; the expected byte order is derived from the
// round-robin rule over whole messages.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N*8-1:0] s_tdata = '0;
    logic [N-1:0] s_tvalid = '0;
    logic [N-1:0] s_tlast = '0;
    logic [N-1:0] s_tready;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic [2:0]   grant;
    logic         busy;
    logic         timeout;
    arb_state_e   dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    // Per-requester message buffers: {last, byte}.
    logic [8:0] rbuf [N][64];
    int rhead [N];
    int rcnt  [N];

    // Expected entries: {owner[2:0], byte[7:0]}.
    logic [10:0] exp_q [$];
    logic [10:0] acc_q [$];

    uart_tx_arbiter #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic clear_bufs();
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rcnt[i]  = 0;
        end
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rcnt[i] > 0) begin
                s_tvalid[i]      = 1'b1;
                s_tdata[8*i +: 8] = rbuf[i][rhead[i]][7:0];
                s_tlast[i]       = rbuf[i][rhead[i]][8];
            end else begin
                s_tvalid[i]      = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]       = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        m_tready = 1'b0;
        clear_bufs();
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        rbuf[r][rhead[r] + rcnt[r]] = {last, d};
        rcnt[r]++;
    endtask

    task automatic push_msg(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            push_byte(r, 8'($urandom_range(0, 255)), (b == len - 1));
        end
    endtask

    // Reference: whole messages leave in round-robin order, starting the
    // search after 'last'; every pending requester stays valid until done.
    task automatic build_expected(input int last);
        int h [N];
        int c [N];
        int ptr;
        int found;
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            h[i] = rhead[i];
            c[i] = rcnt[i];
        end
        ptr = last;
        forever begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                if (found < 0 && c[(ptr + k) % N] > 0) found = (ptr + k) % N;
            end
            if (found < 0) break;
            do begin
                e = rbuf[found][h[found]];
                exp_q.push_back({3'(found), e[7:0]});
                acc_q.push_back({3'(found), e[7:0]});
                h[found]++;
                c[found]--;
            end while (!e[8] && c[found] > 0);
            ptr = found;
        end
    endtask

    // mode 0: m_tready=1; mode 1: random m_tready; mode 2: 50-cycle stall
    // from the first visible byte, then m_tready=1.
    task automatic run_traffic(input int max_cycles, input int mode);
        int cyc;
        int fired;
        int stall_cyc;
        int nrdy;
        logic [7:0] held;
        logic [10:0] e;
        cyc = 0;
        stall_cyc = 0;
        held = 8'h00;
        m_tready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 0);
        drive_inputs();
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            @(negedge clk);
            n_cmp++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_spurious: timeout=%b required 0 (cycle %0d)", timeout, cyc);
            end
            nrdy = 0;
            for (int i = 0; i < N; i++) begin
                if (s_tready[i] === 1'b1) begin
                    nrdy++;
                    n_cmp++;
                    if (busy !== 1'b1 || grant !== 3'(i)) begin
                        n_fail++;
                        $display("FAIL tready_owner: s_tready[%0d]=1 with busy=%b grant=%0d", i, busy, grant);
                    end
                end
            end
            if (nrdy > 1) begin
                n_fail++;
                $display("FAIL tready_onehot: %0d ready bits, required at most 1", nrdy);
            end
            if (mode == 2 && m_tvalid === 1'b1 && stall_cyc < 50) begin
                if (stall_cyc == 0) held = m_tdata;
                n_cmp++;
                if (m_tdata !== held || s_tready !== '0) begin
                    n_fail++;
                    $display("FAIL stall_hold: m_tdata=%h s_tready=%b required %h / 0", m_tdata, s_tready, held);
                end
                stall_cyc++;
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_extra: byte %h with nothing expected", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e[7:0]) begin
                        n_fail++;
                        $display("FAIL out_data: m_tdata=%h required %h (from requester %0d)", m_tdata, e[7:0], e[10:8]);
                    end
                end
            end
            fired = -1;
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i] === 1'b1) fired = i;
            end
            if (fired >= 0) begin
                n_cmp++;
                if (acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL accept_extra: requester %0d accepted with nothing expected", fired);
                end else begin
                    e = acc_q.pop_front();
                    if (int'(e[10:8]) != fired || s_tdata[8*fired +: 8] !== e[7:0]) begin
                        n_fail++;
                        $display("FAIL accept_order: requester %0d byte %h, required requester %0d byte %h",
                                 fired, s_tdata[8*fired +: 8], e[10:8], e[7:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (fired >= 0) begin
                rhead[fired]++;
                rcnt[fired]--;
            end
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = (stall_cyc >= 50);
            endcase
            drive_inputs();
            cyc++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_bound: %0d bytes outstanding after %0d cycles, required 0", exp_q.size(), cyc);
        end
        if (mode == 2) begin
            n_cmp++;
            if (stall_cyc != 50) begin
                n_fail++;
                $display("FAIL stall_len: stalled %0d cycles, required 50", stall_cyc);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || s_tready !== '0) begin
            n_fail++;
            $display("FAIL reset_out: m_tvalid=%b m_tdata=%h s_tready=%b required 0/00/0", m_tvalid, m_tdata, s_tready);
        end
        n_cmp++;
        if (busy !== 1'b0 || grant !== 3'd0 || timeout !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_ctl: busy=%b grant=%0d timeout=%b state=%0d required 0/0/0/0",
                     busy, grant, timeout, dbg_state);
        end
    endtask

    task automatic test_two_single();
        apply_reset();
        push_byte(0, 8'h41, 1'b1);
        push_byte(2, 8'h43, 1'b1);
        build_expected(N - 1);
        run_traffic(100, 0);
    endtask

    task automatic test_contiguous();
        apply_reset();
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        build_expected(N - 1);
        run_traffic(100, 0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_byte(0, 8'hA0, 1'b0);
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hA2, 1'b1);
        push_byte(1, 8'hB0, 1'b1);
        build_expected(N - 1);
        run_traffic(200, 2);
    endtask

    task automatic test_timeout();
        int idle;
        int seen;
        int pulses;
        int nout;
        int fired;
        logic [7:0] outb [4];
        apply_reset();
        push_byte(0, 8'h55, 1'b0);
        push_byte(1, 8'h77, 1'b1);
        m_tready = 1'b1;
        drive_inputs();
        idle = 0;
        seen = -1;
        pulses = 0;
        nout = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                if (seen < 0) begin
                    seen = cyc;
                    n_cmp++;
                    if (idle != TO) begin
                        n_fail++;
                        $display("FAIL timeout_delay: pulse after %0d idle cycles, required %0d", idle, TO);
                    end
                    n_cmp++;
                    if (busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL timeout_busy: busy=%b required 0", busy);
                    end
                end
            end else if (busy === 1'b1 && grant === 3'd0 && s_tvalid[0] === 1'b0) begin
                idle++;
            end
            if (seen >= 0 && cyc == seen + 1) begin
                n_cmp++;
                if (timeout !== 1'b0 || busy !== 1'b1 || grant !== 3'd1) begin
                    n_fail++;
                    $display("FAIL timeout_regrant: timeout=%b busy=%b grant=%0d required 0/1/1", timeout, busy, grant);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1 && nout < 4) begin
                outb[nout] = m_tdata;
                nout++;
            end
            fired = -1;
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i] === 1'b1) fired = i;
            end
            @(posedge clk);
            #1;
            if (fired >= 0) begin
                rhead[fired]++;
                rcnt[fired]--;
            end
            drive_inputs();
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: %0d pulse cycles, required 1", pulses);
        end
        n_cmp++;
        if (nout != 2 || outb[0] !== 8'h55 || outb[1] !== 8'h77) begin
            n_fail++;
            $display("FAIL timeout_bytes: %0d bytes first %h second %h, required 2 bytes 55 77", nout, outb[0], outb[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        apply_reset();
        push_byte(0, 8'hAA, 1'b0);
        m_tready = 1'b0;
        drive_inputs();
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (m_tvalid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || m_tdata !== 8'hAA) begin
            n_fail++;
            $display("FAIL mid_load: m_tvalid=%b m_tdata=%h required 1/AA", m_tvalid, m_tdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || busy !== 1'b0 || s_tready !== '0) begin
            n_fail++;
            $display("FAIL mid_async: m_tvalid=%b m_tdata=%h busy=%b s_tready=%b required 0/00/0/0",
                     m_tvalid, m_tdata, busy, s_tready);
        end
        clear_bufs();
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) push_byte(r, 8'hC0 + 8'(r), 1'b1);
        build_expected(N - 1);
        run_traffic(100, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            apply_reset();
            for (int r = 0; r < N; r++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) push_msg(r, $urandom_range(1, 4));
            end
            build_expected(N - 1);
            run_traffic(3000, 1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_two_single();
        test_contiguous();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
